// File: rtl/if_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Also carries the codebase-wide ENABLE/VALID flags.
package if_stage_pkg;
    localparam logic        ENABLE       = 1'b1;
    localparam logic        VALID        = 1'b1;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_stage_pc_reg.sv
// pc_reg: fetch PC register with sequential increment and word-aligned redirect.
// A redirect always wins over an advance in the same cycle.
module if_stage_pc_reg
    import if_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        advance,
    output logic [31:0] fetch_pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_VECTOR;
        end else if (redirect) begin
            fetch_pc <= redirect_target & ALIGN_MASK;
        end else if (advance) begin
            fetch_pc <= fetch_pc + PC_INC;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding memory request, a one-entry skid
// buffer for stalls, and flush handling that drains a stale request.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_FETCH | request outstanding at fetch_pc
//   ST_HOLD  | fetched word parked in buffer while ID stalls; no request
//   ST_DRAIN | waiting for the ack of a request abandoned by a flush
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] program_counter,
    output logic [31:0] instruction,
    output logic        valid
);

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_ins;
    logic [31:0]  drain_addr;
    logic         pc_advance;

    assign pc_advance = (state == ST_FETCH) && imem_ack && !flush;

    if_stage_pc_reg u_pc_reg (
        .clock           (clock),
        .reset           (reset),
        .redirect        (flush),
        .redirect_target (flush_target),
        .advance         (pc_advance),
        .fetch_pc        (fetch_pc)
    );

    // The address must stay on the abandoned request until its ack shows up.
    assign imem_req  = (state != ST_HOLD) ? ENABLE : ~ENABLE;
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_FETCH;
            program_counter <= RESET_VECTOR;
            instruction     <= NOP_WORD;
            valid           <= 1'b0;
            buf_pc          <= 32'h0;
            buf_ins         <= NOP_WORD;
            drain_addr      <= 32'h0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (flush) begin
                        valid       <= 1'b0;
                        instruction <= NOP_WORD;
                        if (!imem_ack) begin
                            state      <= ST_DRAIN;
                            drain_addr <= fetch_pc;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            buf_pc  <= fetch_pc;
                            buf_ins <= imem_data;
                            state   <= ST_HOLD;
                        end else begin
                            program_counter <= fetch_pc;
                            instruction     <= imem_data;
                            valid           <= VALID;
                        end
                    end else if (!stall) begin
                        valid       <= 1'b0;
                        instruction <= NOP_WORD;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        valid       <= 1'b0;
                        instruction <= NOP_WORD;
                        buf_pc      <= 32'h0;
                        buf_ins     <= NOP_WORD;
                        state       <= ST_FETCH;
                    end else if (!stall) begin
                        program_counter <= buf_pc;
                        instruction     <= buf_ins;
                        valid           <= VALID;
                        state           <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (flush) begin
                        valid       <= 1'b0;
                        instruction <= NOP_WORD;
                    end
                    if (imem_ack) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_if_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] flush_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        valid;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: next fetch address, optional abandoned request, parked word
    logic [31:0] m_pc;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    logic        m_have_buf;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_ins;
    logic        m_valid;
    logic [31:0] m_pcout;
    logic [31:0] m_ins;

    if_stage dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .flush_target    (flush_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .program_counter (program_counter),
        .instruction     (instruction),
        .valid           (valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_stale = 1'b0; m_stale_addr = 32'h0;
        m_have_buf = 1'b0; m_buf_pc = 32'h0; m_buf_ins = 32'h0;
        m_valid = 1'b0; m_pcout = 32'h0; m_ins = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic [31:0] tgt,
                              input logic a, input logic [31:0] d);
        if (f) begin
            // a request still in flight with no ack now becomes one to throw away
            if (!m_have_buf && !a) begin
                if (!m_stale) begin
                    m_stale = 1'b1;
                    m_stale_addr = m_pc;
                end
            end else begin
                m_stale = 1'b0;
            end
            m_have_buf = 1'b0;
            m_pc = tgt & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_ins = 32'h0;
        end else if (m_have_buf) begin
            if (!s) begin
                m_have_buf = 1'b0;
                m_valid = 1'b1;
                m_pcout = m_buf_pc;
                m_ins = m_buf_ins;
            end
        end else if (m_stale) begin
            if (a) m_stale = 1'b0;
        end else if (a) begin
            if (s) begin
                m_have_buf = 1'b1;
                m_buf_pc = m_pc;
                m_buf_ins = d;
            end else begin
                m_valid = 1'b1;
                m_pcout = m_pc;
                m_ins = d;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_valid = 1'b0;
            m_ins = 32'h0;
        end
    endtask

    task automatic check_outputs();
        chk("valid", {31'h0, valid}, {31'h0, m_valid});
        chk("program_counter", program_counter, m_pcout);
        chk("instruction", instruction, m_ins);
        chk("imem_req", {31'h0, imem_req}, {31'h0, !m_have_buf});
        if (!m_have_buf)
            chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    endtask

    // Called at a falling edge: drive, step model at rising edge, check at next falling edge.
    task automatic cyc(input logic s, input logic f, input logic [31:0] tgt, input logic a);
        logic        a_eff;
        logic [31:0] d;
        a_eff = a && !m_have_buf;
        d = $urandom;
        stall = s; flush = f; flush_target = tgt; imem_ack = a_eff; imem_data = d;
        @(posedge clock);
        model_step(s, f, tgt, a_eff, d);
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; flush_target = 32'h0;
        imem_ack = 1'b0; imem_data = 32'h0;
        model_reset();
        repeat (2) @(negedge clock);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        @(negedge clock);
        check_outputs();
        reset = 1'b1;
        imem_ack = 1'b0;
        #1;
        chk("req_after_reset", {31'h0, imem_req}, 32'h1);
        chk("addr_after_reset", imem_addr, 32'h0);

        // zero-wait acks: PCs 0,4,8,...
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_pc", program_counter, 32'h14);

        // ack under stall, stall held for three more cycles, then release
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            chk("hold_req", {31'h0, imem_req}, 32'h0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("hold_release_pc", program_counter, 32'h18);

        // flush without ack to 0x103, stale ack two cycles later
        cyc(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_valid", {31'h0, valid}, 32'h0);
        chk("drain_next_addr", imem_addr, 32'h0000_0100);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // flush with same-cycle ack to 0x40
        cyc(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        chk("flush_ack_valid", {31'h0, valid}, 32'h0);
        chk("flush_ack_addr", imem_addr, 32'h0000_0040);

        // wrap at the top of the address space
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc0", program_counter, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc1", program_counter, 32'h0000_0000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                $urandom, ($urandom_range(0, 9) < 6));
        end

        // reset asserted while a word is parked in the buffer
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_pc", program_counter, 32'h0);
        model_reset();
        stall = 1'b0; imem_ack = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("restart_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("restart_pc", program_counter, 32'hC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low; asserted = 0.
REQ-003 SHALL: stall  input  1  downstream hold; outputs to ID frozen while 1.
REQ-004 SHALL: flush  input  1  redirect request; discards in-flight work.
REQ-005 SHALL: flush_target  input  32  new fetch address; bits [1:0] forced to 0 internally.
REQ-006 SHALL: imem_req  output  1  instruction-memory read request.
REQ-007 SHALL: imem_addr  output  32  word address of the request; stable while imem_req=1 and no imem_ack.
REQ-008 SHALL: imem_ack  input  1  single-cycle completion pulse; valid only while imem_req=1; may arrive in the first request cycle.
REQ-009 SHALL: imem_data  input  32  instruction word, valid in the imem_ack cycle.
REQ-010 SHALL: program_counter  output  32  registered PC of the instruction presented to ID.
REQ-011 SHALL: instruction  output  32  registered instruction to ID; 0 (NOP) when no valid instruction.
REQ-012 SHALL: valid  output  1  registered; 1 = program_counter/instruction hold a real fetched instruction.

Function
REQ-013 SHALL: states FETCH, HOLD, DRAIN; exactly one memory request outstanding at most.
REQ-014 SHALL: FETCH -- imem_req=1, imem_addr=fetch_pc; HOLD -- imem_req=0; DRAIN -- imem_req=1, imem_addr=stale request address.
REQ-015 SHALL: FETCH, ack, no stall, no flush -> outputs load {fetch_pc, imem_data}, valid=1, fetch_pc+=4 (mod 2^32, wrap 0xFFFFFFFC->0), stay FETCH.
REQ-016 SHALL: FETCH, no ack, no stall, no flush -> bubble next cycle: valid=0, instruction=0, program_counter held.
REQ-017 SHALL: FETCH, ack, stall, no flush -> imem_data/fetch_pc captured in 1-entry buffer, fetch_pc+=4, outputs held, go HOLD.
REQ-018 SHALL: FETCH, no ack, stall -> outputs held, request remains, stay FETCH.
REQ-019 SHALL: HOLD, stall=1 -> all state held; HOLD, stall=0 -> outputs load buffer, valid=1, go FETCH.
REQ-020 SHALL: flush has priority over stall and ack in every state; next cycle valid=0, instruction=0, fetch_pc=flush_target & ~3.
REQ-021 SHALL: flush in FETCH with same-cycle ack -> ack data discarded, stay FETCH (new address next cycle).
REQ-022 SHALL: flush in FETCH without ack -> go DRAIN; the pending ack is later discarded, then FETCH.
REQ-023 SHALL: flush in HOLD -> buffer discarded, go FETCH; flush in DRAIN -> fetch_pc updated, stay DRAIN until ack.
REQ-024 SHALL: ack in DRAIN without flush -> data discarded, go FETCH next cycle; no output change.
REQ-025 SHALL: fetch-to-ID latency with zero-wait memory = 1 cycle after ack; sustained throughput 1 instruction/cycle.

Reset
REQ-026 SHALL: reset=0 asynchronously forces state=FETCH, fetch_pc=0, program_counter=0, instruction=0, valid=0, buffer cleared.
REQ-027 SHALL: imem_req=1 with imem_addr=0 in the first clock after reset deasserts.
REQ-028 SHALL: reset mid-request abandons the outstanding request; any ack during reset is ignored.

Structure
REQ-029 SHALL: reset vector, NOP word, PC increment and state encodings defined in shared macro.v, alongside existing ENABLE/VALID constants.
REQ-030 SHALL: PC register plus increment/redirect logic isolated in sub-module pc_reg; FSM and buffer in if_stage.

Verification
REQ-031 SHALL: zero-wait ack every cycle from reset -> valid rises cycle 2, program_counter 0,4,8,... with instruction matching imem_data.
REQ-032 SHALL: ack at addr 0x8 while stall=1 for 3 cycles -> outputs held, imem_req=0, then 0x8 presented the cycle stall falls.
REQ-033 SHALL: flush_target=0x103 without ack, ack 2 cycles later -> that data never reaches ID; next request addr 0x100.
REQ-034 SHALL: flush and ack same cycle, flush_target=0x40 -> valid=0 next cycle, imem_addr=0x40 next cycle.
REQ-035 SHALL: flush_target=0xFFFFFFFC, two acks -> program_counter 0xFFFFFFFC then 0x00000000.
REQ-036 SHALL: reset=0 asserted mid-HOLD -> immediately valid=0, instruction=0; fetch restarts at 0 after release.
